// File: rtl/emtf_inj_pkg.sv
`default_nettype none
// ============================================================================
// Module  : emtf_inj_pkg
// Brief   : Shared types and sizes for the injection-memory sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package emtf_inj_pkg;

    localparam int INJ_DEPTH = 1024;
    localparam int INJ_AW    = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WINDOW = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } inj_state_t;

endpackage
`default_nettype wire

// File: rtl/inj_down_cnt.sv
`default_nettype none
// ============================================================================
// Module  : inj_down_cnt
// Brief   : Loadable down-counter that parks at zero and flags it.
// Revision: 1.0 - initial release
// ============================================================================
module inj_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk40,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/inject_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inject_seq_ctrl
// Brief   : Sequences launch / window / gap runs of the injection memories.
// Revision: 1.0 - initial release
// ============================================================================
module inject_seq_ctrl
    import emtf_inj_pkg::*;
#(
    parameter int DEPTH    = INJ_DEPTH,
    parameter int SYNC_LAT = 3,
    parameter int PULSE_W  = 4,
    parameter int CW       = 16
) (
    input  logic              clk40,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_trig_en,
    input  logic [CW-1:0]     cfg_nruns,
    input  logic [CW-1:0]     cfg_gap,
    input  logic              trig_in,
    output logic              inject,
    output logic              win_active,
    output logic [INJ_AW-1:0] win_addr,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     runs_done,
    output logic              trig_miss
);

    // Launch lasts long enough for both the inject pulse and the memory sync delay.
    localparam int            c_launch_len  = (PULSE_W > SYNC_LAT) ? PULSE_W : SYNC_LAT;
    localparam logic [CW-1:0] c_launch_last = CW'(c_launch_len - 1);
    localparam logic [CW-1:0] c_inj_hold    = CW'(c_launch_len - PULSE_W);
    localparam logic [CW-1:0] c_win_last    = CW'(DEPTH - 1);

    inj_state_t     r_state;
    inj_state_t     w_state_nxt;
    logic           r_trig_q;
    logic           r_ten;
    logic [CW-1:0]  r_nruns;
    logic [CW-1:0]  r_gap;
    logic           r_stop_pend;
    logic           r_inject;
    logic           r_win_active;
    logic           r_busy;
    logic           r_done;
    logic [CW-1:0]  r_runs;
    logic           r_miss;

    logic           w_trig_rise;
    logic           w_stop_now;
    logic           w_last_run;
    logic           w_accept;
    logic           w_win_end;
    logic           w_in_run;
    logic           w_inject_nxt;
    logic           w_cnt_load;
    logic [CW-1:0]  w_cnt_val;
    logic [CW-1:0]  w_cnt;
    logic           w_cnt_zero;

    inj_down_cnt #(.W(CW)) u_cnt (
        .clk40      (clk40),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    assign w_trig_rise = trig_in & ~r_trig_q;
    assign w_stop_now  = r_stop_pend | cfg_stop;
    assign w_in_run    = (r_state == ST_LAUNCH) || (r_state == ST_WINDOW);
    assign w_last_run  = (r_nruns != '0) && (({1'b0, r_runs} + 1'b1) == {1'b0, r_nruns});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_accept    = 1'b0;
        w_win_end   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    w_state_nxt = ST_ARM;
                    w_accept    = 1'b1;
                end
            end
            ST_ARM: begin
                if (cfg_stop) begin
                    w_state_nxt = ST_DONE;
                end else if (!r_ten || w_trig_rise) begin
                    w_state_nxt = ST_LAUNCH;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_launch_last;
                end
            end
            ST_LAUNCH: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WINDOW;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_win_last;
                end
            end
            ST_WINDOW: begin
                if (w_cnt_zero) begin
                    w_win_end = 1'b1;
                    if (w_stop_now || w_last_run) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_gap != '0) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = r_gap - 1'b1;
                    end else begin
                        w_state_nxt = ST_ARM;
                    end
                end
            end
            ST_GAP: begin
                if (w_stop_now) begin
                    w_state_nxt = ST_DONE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_ARM;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // While staying in launch, next cycle keeps inject if the counter is still above the hold tail.
    assign w_inject_nxt = (w_state_nxt == ST_LAUNCH) &&
                          ((r_state != ST_LAUNCH) || (w_cnt > c_inj_hold));

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_trig_q     <= 1'b0;
            r_inject     <= 1'b0;
            r_win_active <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_trig_q     <= trig_in;
            r_inject     <= w_inject_nxt;
            r_win_active <= (w_state_nxt == ST_WINDOW);
            r_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        end
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            r_ten       <= 1'b0;
            r_nruns     <= '0;
            r_gap       <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_runs      <= '0;
            r_miss      <= 1'b0;
        end else if (w_accept) begin
            r_ten       <= cfg_trig_en;
            r_nruns     <= cfg_nruns;
            r_gap       <= cfg_gap;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_runs      <= '0;
            r_miss      <= 1'b0;
        end else begin
            if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                r_done <= 1'b1;
            end
            if (w_in_run && cfg_stop) begin
                r_stop_pend <= 1'b1;
            end
            if (w_in_run && w_trig_rise) begin
                r_miss <= 1'b1;
            end
            if (w_win_end && (r_runs != '1)) begin
                r_runs <= r_runs + 1'b1;
            end
        end
    end

    assign inject     = r_inject;
    assign win_active = r_win_active;
    assign win_addr   = r_win_active ? INJ_AW'(c_win_last - w_cnt) : '0;
    assign busy       = r_busy;
    assign done       = r_done;
    assign runs_done  = r_runs;
    assign trig_miss  = r_miss;

endmodule
`default_nettype wire
